// File: rtl/POLI_types_pkg.sv
// Shared widths, FSM state encoding and small helpers for the two-requester APB arbiter.
package POLI_types_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_t;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin arbitration in IDLE, then one SETUP/ACCESS transfer.
// Optional ACCESS-phase timeout abort is built when APB_TIMEOUT_EN is defined.
module apb_arbiter
    import POLI_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             req_valid,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [1:0]             req_write,
    input  logic [2*WORD_SIZE-1:0] req_wdata,
    output logic [1:0]             req_ack,
    output logic [1:0]             req_done,
    output logic [WORD_SIZE-1:0]   rdata,
    output logic                   err,
    output logic                   PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [ADDR_SIZE-1:0]   PADDR,
    output logic [WORD_SIZE-1:0]   PWDATA,
    input  logic                   PREADY,
    input  logic [WORD_SIZE-1:0]   PRDATA
);

    apb_arb_state_t         state_r, state_s;
    logic                   grant_r, grant_s;
    logic                   last_r, last_s;
    logic                   sel_s;
    logic [1:0]             ack_s;
    logic                   psel_r, psel_s;
    logic                   penable_r, penable_s;
    logic                   pwrite_r, pwrite_s;
    logic [ADDR_SIZE-1:0]   paddr_r, paddr_s;
    logic [WORD_SIZE-1:0]   pwdata_r, pwdata_s;
    logic [WORD_SIZE-1:0]   rdata_r, rdata_s;
    logic [1:0]             done_r, done_s;

`ifdef APB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCW-1:0]         cnt_r, cnt_s;
    logic                   err_r, err_s;
`endif

    // Next-state, arbitration and next-value logic for every registered output.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        last_s    = last_r;
        sel_s     = 1'b0;
        ack_s     = 2'b00;
        psel_s    = psel_r;
        penable_s = penable_r;
        pwrite_s  = pwrite_r;
        paddr_s   = paddr_r;
        pwdata_s  = pwdata_r;
        rdata_s   = rdata_r;
        done_s    = 2'b00;
`ifdef APB_TIMEOUT_EN
        cnt_s     = cnt_r;
        err_s     = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    // On a tie the requester not served last wins; a lone requester always wins.
                    if (req_valid == 2'b11) begin
                        sel_s = ~last_r;
                    end else begin
                        sel_s = req_valid[1];
                    end
                    ack_s     = idx_to_onehot(sel_s);
                    grant_s   = sel_s;
                    paddr_s   = sel_s ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
                    pwdata_s  = sel_s ? req_wdata[2*WORD_SIZE-1:WORD_SIZE] : req_wdata[WORD_SIZE-1:0];
                    pwrite_s  = req_write[sel_s];
                    psel_s    = 1'b1;
                    penable_s = 1'b0;
                    state_s   = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                penable_s = 1'b1;
                state_s   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_s     = {TCW{1'b0}};
`endif
            end
            ACCESS: begin
                if (PREADY) begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    done_s    = idx_to_onehot(grant_r);
                    last_s    = grant_r;
                    state_s   = IDLE;
                    if (!pwrite_r) begin
                        rdata_s = PRDATA;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_r == TCW'(TIMEOUT_CYCLES - 1)) begin
                    psel_s    = 1'b0;
                    penable_s = 1'b0;
                    done_s    = idx_to_onehot(grant_r);
                    last_s    = grant_r;
                    rdata_s   = {WORD_SIZE{1'b0}};
                    err_s     = 1'b1;
                    state_s   = IDLE;
                end else begin
                    cnt_s = cnt_r + TCW'(1);
                end
`else
                else begin
                    state_s = ACCESS;
                end
`endif
            end
            default: begin
                psel_s    = 1'b0;
                penable_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer without a completion pulse.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            grant_r   <= 1'b0;
            last_r    <= 1'b1;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_SIZE{1'b0}};
            pwdata_r  <= {WORD_SIZE{1'b0}};
            rdata_r   <= {WORD_SIZE{1'b0}};
            done_r    <= 2'b00;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            last_r    <= last_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            pwrite_r  <= pwrite_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            rdata_r   <= rdata_s;
            done_r    <= done_s;
        end
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS-phase wait counter and timeout flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_r <= {TCW{1'b0}};
            err_r <= 1'b0;
        end else begin
            cnt_r <= cnt_s;
            err_r <= err_s;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    // Acknowledge is combinational so the requester sees it in the arbitration cycle.
    assign req_ack  = ack_s & {2{nRST}};
    assign req_done = done_r;
    assign rdata    = rdata_r;
    assign PSEL     = psel_r;
    assign PENABLE  = penable_r;
    assign PWRITE   = pwrite_r;
    assign PADDR    = paddr_r;
    assign PWDATA   = pwdata_r;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: completions are checked by a scoreboard monitor.
module tb_apb_arbiter;
    import POLI_types_pkg::*;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [1:0]             req_valid;
    logic [2*ADDR_SIZE-1:0] req_addr;
    logic [1:0]             req_write;
    logic [2*WORD_SIZE-1:0] req_wdata;
    logic [1:0]             req_ack;
    logic [1:0]             req_done;
    logic [WORD_SIZE-1:0]   rdata;
    logic                   err;
    logic                   PSEL, PENABLE, PWRITE;
    logic [ADDR_SIZE-1:0]   PADDR;
    logic [WORD_SIZE-1:0]   PWDATA;
    logic                   PREADY;
    logic [WORD_SIZE-1:0]   PRDATA;

    apb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_done(req_done), .rdata(rdata), .err(err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: every completion pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (req_done !== 2'b00) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {62'd0, req_done}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done", {62'd0, req_done}, {62'd0, mon_e.done});
                check("rdata", {32'd0, rdata}, {32'd0, mon_e.rd});
                check("err", {63'd0, err}, {63'd0, mon_e.er});
            end
        end
    end

    // Runs one transfer starting just after a rising edge; returns just after the done edge.
    task automatic xfer(input logic [1:0] vmask, input logic [1:0] eg, input logic [1:0] wr,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int waits, input logic [31:0] prd, input logic [31:0] exp_rd);
        logic [31:0] ea, ed;
        logic        ew;
        ea = eg[1] ? a1 : a0;
        ed = eg[1] ? d1 : d0;
        ew = eg[1] ? wr[1] : wr[0];
        req_valid = vmask;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        req_write = wr;
        @(negedge CLK);
        check("ack", {62'd0, req_ack}, {62'd0, eg});
        sb_q.push_back('{done: eg, rd: exp_rd, er: 1'b0});
        @(posedge CLK); #1;
        req_valid = req_valid & ~eg;
        @(negedge CLK);
        check("setup_psel_penable", {62'd0, PSEL, PENABLE}, {62'd0, 2'b10});
        check("setup_paddr", {32'd0, PADDR}, {32'd0, ea});
        check("setup_pwdata", {32'd0, PWDATA}, {32'd0, ed});
        check("setup_pwrite", {63'd0, PWRITE}, {63'd0, ew});
        @(posedge CLK); #1;
        PREADY = (waits == 0);
        PRDATA = prd;
        @(negedge CLK);
        check("access_psel_penable", {62'd0, PSEL, PENABLE}, {62'd0, 2'b11});
        for (int w = 0; w < waits; w++) begin
            @(posedge CLK); #1;
            PREADY = (w == waits - 1);
            @(negedge CLK);
            check("wait_stable", {PSEL, PENABLE, PWRITE, PADDR, PWDATA[27:0]},
                  {1'b1, 1'b1, ew, ea, ed[27:0]});
        end
        @(posedge CLK); #1;
        PREADY = 1'b0;
        check("idle_psel_penable", {62'd0, PSEL, PENABLE}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b0; req_valid = 2'b00; req_addr = '0; req_write = 2'b00; req_wdata = '0;
        PREADY = 1'b0; PRDATA = 32'd0;
        #1;
        check("reset_outputs", {PSEL, PENABLE, PWRITE, req_ack, req_done, err, PADDR[24:0]}, 64'd0);
        check("reset_data", {PWDATA, rdata}, 64'd0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;

        // Write from requester 0 with zero wait states.
        xfer(2'b01, 2'b01, 2'b01, 32'h0000_0004, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, 32'h0);
        // Read from requester 1.
        xfer(2'b10, 2'b10, 2'b00, 32'h0, 32'h0000_0100, 32'h0, 32'h0, 0, 32'h1234_5678, 32'h1234_5678);
        // Write with PREADY delayed 3 cycles: rdata holds the previous read.
        xfer(2'b01, 2'b01, 2'b01, 32'h0000_0010, 32'h0, 32'hA5A5_0F0F, 32'h0, 3, 32'hFFFF_FFFF, 32'h1234_5678);

        // Reset in the middle of ACCESS.
        req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, 32'h0000_0020};
        @(negedge CLK);
        check("rst_ack", {62'd0, req_ack}, 64'd1);
        @(posedge CLK); #1; req_valid = 2'b00;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("rst_in_access", {62'd0, PSEL, PENABLE}, {62'd0, 2'b11});
        #2; nRST = 1'b0; req_valid = 2'b11;
        #1;
        check("rst_mid_outputs", {PSEL, PENABLE, PWRITE, req_ack, req_done, err, PADDR[24:0]}, 64'd0);
        check("rst_mid_data", {PWDATA, rdata}, 64'd0);
        @(negedge CLK); req_valid = 2'b00; nRST = 1'b1;
        @(posedge CLK); #1;

        // Both requesters valid: grants alternate starting with requester 0.
        xfer(2'b11, 2'b01, 2'b00, 32'h100, 32'h200, 32'h0, 32'h0, 0, 32'h1111_0000, 32'h1111_0000);
        xfer(2'b11, 2'b10, 2'b00, 32'h104, 32'h204, 32'h0, 32'h0, 1, 32'h1111_0001, 32'h1111_0001);
        xfer(2'b11, 2'b01, 2'b00, 32'h108, 32'h208, 32'h0, 32'h0, 0, 32'h1111_0002, 32'h1111_0002);
        xfer(2'b11, 2'b10, 2'b11, 32'h10C, 32'h20C, 32'h5, 32'h6, 0, 32'h1111_0003, 32'h1111_0002);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after 16 ACCESS cycles with err.
        req_valid = 2'b10; req_write = 2'b00; req_addr = {32'h0000_0300, 32'h0};
        @(negedge CLK);
        check("tmo_ack", {62'd0, req_ack}, 64'd2);
        sb_q.push_back('{done: 2'b10, rd: 32'h0, er: 1'b1});
        @(posedge CLK); #1; req_valid = 2'b00;
        @(posedge CLK); #1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            check("tmo_access_held", {62'd0, PSEL, PENABLE}, {62'd0, 2'b11});
            @(posedge CLK); #1;
        end
        check("tmo_psel_dropped", {62'd0, PSEL, PENABLE}, 64'd0);
`endif

        repeat (3) @(posedge CLK);
        #1;
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
